// File: rtl/md_unit.sv
// md_unit: multiply/divide responder for the Execute stage.
// Accepts MULT/MULTU/DIV/DIVU on start, computes the 64-bit result up front,
// then holds it pending for a fixed number of busy cycles before committing
// it to the HI/LO architectural registers. MTHI/MTLO write HI/LO directly
// when the unit is idle.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset (aborts any operation in flight)
//   start  : issue a multiply/divide this cycle (ignored while busy)
//   md_op  : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   src_a  : RS operand; also the MTHI/MTLO write data
//   src_b  : RT operand
//   hi_we  : MTHI, write src_a to HI (idle and no start only)
//   lo_we  : MTLO, write src_a to LO (idle and no start only)
//   busy   : operation in flight
//   hi, lo : HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   res_q, res_d;     // pending {hi_res, lo_res}
  logic          res_wr_q, res_wr_d; // pending result is to be committed

  // Arithmetic on the live operands; only used on the start edge.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_s_den, div_u_den;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_zero;
  logic [63:0] result;

  always_comb begin
    // Low 64 bits of a product of sign-extended operands equal the signed product.
    a_sx   = {{32{src_a[31]}}, src_a};
    b_sx   = {{32{src_b[31]}}, src_b};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without special casing.
    div_zero  = (src_b == 32'd0);
    a_mag     = src_a[31] ? (~src_a + 32'd1) : src_a;
    b_mag     = src_b[31] ? (~src_b + 32'd1) : src_b;
    // Substitute a divisor of 1 when dividing by zero; the result is discarded.
    div_s_den = div_zero ? 32'd1 : b_mag;
    div_u_den = div_zero ? 32'd1 : src_b;
    q_mag     = a_mag / div_s_den;
    r_mag     = a_mag % div_s_den;
    q_s       = (src_a[31] ^ src_b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s       = src_a[31] ? (~r_mag + 32'd1) : r_mag;
    q_u       = src_a / div_u_den;
    r_u       = src_a % div_u_den;

    unique case (md_op)
      2'b00:   result = prod_s;
      2'b01:   result = prod_u;
      2'b10:   result = {r_s, q_s};
      default: result = {r_u, q_u};
    endcase
  end

  // NOTE: every signal is given its hold value first so no path through the
  // case leaves one unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    res_wr_d = res_wr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // start wins over a same-cycle MTHI/MTLO.
          state_d  = RUN;
          cnt_d    = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          res_d    = result;
          res_wr_d = !(md_op[1] && div_zero);
        end else begin
          if (hi_we) hi_d = src_a;
          if (lo_we) lo_d = src_a;
        end
      end
      RUN: begin
        // start/hi_we/lo_we are ignored here; HI/LO hold until completion.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = IDLE;
          res_wr_d = 1'b0;
          if (res_wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      // NOTE: the pending result is reset too, so an aborted operation
      // can never leak into HI/LO afterwards.
      res_q    <= '0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      res_wr_q <= res_wr_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand-written
// multi-cycle corner sequences, and randomized operations against a
// behavioural reference model.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi, m_lo;   // architectural HI/LO as the bench expects them

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {commit, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int             ia, ib;
    longint         sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: ref_op = {1'b1, 64'(sa * sb)};
      2'd1: ref_op = {1'b1, ua * ub};
      2'd2: begin
        if (b == 32'd0) ref_op = {1'b0, 64'd0};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_op = {1'b1, r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) ref_op = {1'b0, 64'd0};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          ref_op = {1'b1, ur[31:0], uq[31:0]};
        end
      end
    endcase
  endfunction

  // Issue one operation at the next edge, track busy length and HI/LO hold,
  // then compare the committed HI/LO. with_we also raises hi_we/lo_we with
  // start; inject pulses start and hi_we mid-operation (both must be ignored).
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit with_we, input bit inject);
    int cycles;
    bit hold_bad;
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    hi_we = with_we;
    lo_we = with_we;
    tick();
    cycles   = 0;
    hold_bad = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      if (hi !== m_hi || lo !== m_lo) hold_bad = 1'b1;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (inject && cycles == 2) begin
        start = 1'b1;
        md_op = 2'b10;
        src_a = 32'd9;
        src_b = 32'd3;
      end
      if (inject && cycles == 3) begin
        hi_we = 1'b1;
        src_a = 32'hDEAD;
      end
      tick();
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    check({name, " busy_cycles"}, 64'(cycles), 64'(op[1] ? DIV_N : MULT_N));
    check({name, " hold"}, {63'd0, hold_bad}, 64'd0);
    check({name, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({name, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic move(input bit wh, input bit wl, input logic [31:0] v);
    hi_we = wh;
    lo_we = wl;
    src_a = v;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    check("mt hi", {32'd0, hi}, {32'd0, m_hi});
    check("mt lo", {32'd0, lo}, {32'd0, m_lo});
    check("mt busy", {63'd0, busy}, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [64:0] r;
    logic [1:0]  op;
    logic [31:0] a, b;

    reset = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    md_op = 2'b00;
    src_a = '0;
    src_b = '0;
    m_hi  = '0;
    m_lo  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);

    // Issued back-to-back: each starts the cycle after busy falls.
    vecs[0] = '{2'b00, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b11, 32'd7,        32'd2,        32'd1,        32'd3};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, 1'b0);

    // MTHI, MTLO, then divide by zero leaves them untouched.
    move(1'b1, 1'b0, 32'h1234);
    move(1'b0, 1'b1, 32'h5678);
    run_op("div0", 2'b10, 32'd55, 32'd0, 32'h1234, 32'h5678, 1'b0, 1'b0);
    run_op("divu0", 2'b11, 32'd55, 32'd0, 32'h1234, 32'h5678, 1'b0, 1'b0);
    move(1'b1, 1'b1, 32'hCAFE);

    // start with MTHI/MTLO in the same cycle: writes dropped.
    run_op("start_we", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b0);

    // start and hi_we while busy are ignored.
    run_op("ignore", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);

    // Reset during busy cycle 3 of DIV 100/7 aborts it.
    start = 1'b1;
    md_op = 2'b10;
    src_a = 32'd100;
    src_b = 32'd7;
    tick();
    start = 1'b0;
    check("abort busy1", {63'd0, busy}, 64'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort hi", {32'd0, hi}, 64'd0);
    check("abort lo", {32'd0, lo}, 64'd0);
    begin
      bit late = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) late = 1'b1;
      end
      check("abort no_commit", {63'd0, late}, 64'd0);
    end

    // Randomized operations and moves against the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
          2: b = 32'($urandom_range(1, 16));
          default: ;
        endcase
        r = ref_op(op, a, b);
        if (r[64]) run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, r[63:32], r[31:0], 1'b0, 1'b0);
        else       run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, m_hi, m_lo, 1'b0, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
